// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit: a registered state sequencing fetch, decode,
// memory, ALU, branch and jump steps, with datapath controls decoded from the state.
module main_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  state_t state_q;
  state_t state_d;
  ctl_t   ctl;

  function automatic logic known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // NOTE: asynchronous reset in the sensitivity list, and <= for every registered
  // assignment so all flops sample their inputs from the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // The IR still holds the instruction, so lw/sw is re-resolved here.
      S_MEMADR: begin
        if      (opcode == OP_LW) state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_src    = PC_ALU;
        ctl.ir_write  = mem_ready;
        ctl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_BOFF;
        ctl.alu_op    = ALU_ADD;
        ctl.illegal   = ~known_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PC_TARGET;
        ctl.pc_en     = zero;
      end
      S_ADDIWB:  ctl.reg_write = 1'b1;
      S_JUMP: begin
        ctl.pc_src = PC_JUMP;
        ctl.pc_en  = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Enables are gated by reset directly so an abort takes effect without a clock.
  assign pc_en      = ctl.pc_en     & ~reset;
  assign ir_write   = ctl.ir_write  & ~reset;
  assign reg_write  = ctl.reg_write & ~reset;
  assign mem_write  = ctl.mem_write & ~reset;
  assign mem_read   = ctl.mem_read  & ~reset;
  assign illegal    = ctl.illegal   & ~reset;
  assign iord       = ctl.iord;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_dst    = ctl.reg_dst;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign pc_src     = ctl.pc_src;
  assign state      = state_q;

  mem_exclusive: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: each stimulus cycle queues its expected
// state and control word; a negedge monitor pops and compares.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic       illegal;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Control word: pc_en iord mem_read mem_write ir_write mem_to_reg reg_dst
  // reg_write alu_src_a | alu_src_b | alu_op | pc_src | illegal
  localparam logic [15:0] C_FETCH_WAIT = 16'b0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_FETCH_GO   = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_RST_FETCH  = 16'b0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_DECODE     = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] C_DECODE_ILL = 16'b0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [15:0] C_MEMADR     = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] C_MEMRD      = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_MEMWB      = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] C_MEMWR      = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_EXEC       = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] C_ALUWB      = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] C_BR_TAKEN   = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] C_BR_NOT     = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] C_ADDIEX     = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] C_ADDIWB     = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [15:0] C_JUMP       = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;

  typedef struct {
    string       name;
    logic [19:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [19:0] mon_act;
  int          n_checks = 0;
  int          n_fail = 0;

  // One cycle of stimulus: drive inputs just after the edge, queue what the DUT must show.
  task automatic step(input string name, input logic rst, input logic [5:0] op,
                      input logic z, input logic mr, input logic [3:0] st,
                      input logic [15:0] ctl);
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    sb.push_back('{name, {st, ctl}});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = {state, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                 reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
      n_checks++;
      if (mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                 mon_e.name, mon_act[19:16], mon_act[15:0], mon_e.exp[19:16], mon_e.exp[15:0]);
      end
      n_checks++;
      if (mem_read && mem_write) begin
        n_fail++;
        $display("FAIL %s.mem_excl: got mem_read=1 mem_write=1, expected not both", mon_e.name);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, expected finish");
    $fatal(1);
  end

  initial begin
    // Held in reset with mem_ready=1: FETCH enables stay forced low.
    step("rst0", 1, OP_LW, 0, 1, 4'd0, C_RST_FETCH);
    step("rst1", 1, OP_LW, 0, 1, 4'd0, C_RST_FETCH);

    // lw, no wait: 0,1,2,3,4
    step("lw.fetch",  0, OP_LW, 0, 1, 4'd0, C_FETCH_GO);
    step("lw.decode", 0, OP_LW, 0, 1, 4'd1, C_DECODE);
    step("lw.memadr", 0, OP_LW, 0, 1, 4'd2, C_MEMADR);
    step("lw.memrd",  0, OP_LW, 0, 1, 4'd3, C_MEMRD);
    step("lw.memwb",  0, OP_LW, 0, 1, 4'd4, C_MEMWB);

    // sw with three wait cycles in MEMWR
    step("sw.fetch",  0, OP_SW, 0, 1, 4'd0, C_FETCH_GO);
    step("sw.decode", 0, OP_SW, 0, 1, 4'd1, C_DECODE);
    step("sw.memadr", 0, OP_SW, 0, 1, 4'd2, C_MEMADR);
    step("sw.wait0",  0, OP_SW, 0, 0, 4'd5, C_MEMWR);
    step("sw.wait1",  0, OP_SW, 0, 0, 4'd5, C_MEMWR);
    step("sw.wait2",  0, OP_SW, 0, 0, 4'd5, C_MEMWR);
    step("sw.done",   0, OP_SW, 0, 1, 4'd5, C_MEMWR);

    // R-type with two FETCH wait cycles
    step("r.fwait0", 0, OP_R, 0, 0, 4'd0, C_FETCH_WAIT);
    step("r.fwait1", 0, OP_R, 0, 0, 4'd0, C_FETCH_WAIT);
    step("r.fetch",  0, OP_R, 0, 1, 4'd0, C_FETCH_GO);
    step("r.decode", 0, OP_R, 0, 1, 4'd1, C_DECODE);
    step("r.exec",   0, OP_R, 0, 1, 4'd6, C_EXEC);
    step("r.aluwb",  0, OP_R, 0, 1, 4'd7, C_ALUWB);

    step("addi.fetch",  0, OP_ADDI, 0, 1, 4'd0, C_FETCH_GO);
    step("addi.decode", 0, OP_ADDI, 0, 1, 4'd1, C_DECODE);
    step("addi.ex",     0, OP_ADDI, 0, 1, 4'd9, C_ADDIEX);
    step("addi.wb",     0, OP_ADDI, 0, 1, 4'd10, C_ADDIWB);

    step("beqt.fetch",  0, OP_BEQ, 1, 1, 4'd0, C_FETCH_GO);
    step("beqt.decode", 0, OP_BEQ, 1, 1, 4'd1, C_DECODE);
    step("beqt.branch", 0, OP_BEQ, 1, 1, 4'd8, C_BR_TAKEN);
    step("beqn.fetch",  0, OP_BEQ, 0, 1, 4'd0, C_FETCH_GO);
    step("beqn.decode", 0, OP_BEQ, 0, 1, 4'd1, C_DECODE);
    step("beqn.branch", 0, OP_BEQ, 0, 1, 4'd8, C_BR_NOT);

    step("j.fetch",  0, OP_J, 0, 1, 4'd0, C_FETCH_GO);
    step("j.decode", 0, OP_J, 0, 1, 4'd1, C_DECODE);
    step("j.jump",   0, OP_J, 0, 1, 4'd11, C_JUMP);

    step("ill.fetch",  0, OP_BAD, 0, 1, 4'd0, C_FETCH_GO);
    step("ill.decode", 0, OP_BAD, 0, 1, 4'd1, C_DECODE_ILL);

    // lw stalled in MEMRD, then reset asserted between edges
    step("ab.fetch",  0, OP_LW, 0, 1, 4'd0, C_FETCH_GO);
    step("ab.decode", 0, OP_LW, 0, 1, 4'd1, C_DECODE);
    step("ab.memadr", 0, OP_LW, 0, 1, 4'd2, C_MEMADR);
    step("ab.memrd",  0, OP_LW, 0, 0, 4'd3, C_MEMRD);
    step("ab.reset",  1, OP_LW, 0, 0, 4'd0, C_RST_FETCH);
    step("ab.hold",   1, OP_LW, 0, 1, 4'd0, C_RST_FETCH);

    step("post.fetch",  0, OP_LW, 0, 1, 4'd0, C_FETCH_GO);
    step("post.decode", 0, OP_LW, 0, 1, 4'd1, C_DECODE);
    step("post.memadr", 0, OP_LW, 0, 1, 4'd2, C_MEMADR);
    step("post.memrd",  0, OP_LW, 0, 1, 4'd3, C_MEMRD);
    step("post.memwb",  0, OP_LW, 0, 1, 4'd4, C_MEMWB);
    step("post.next",   0, OP_LW, 0, 0, 4'd0, C_FETCH_WAIT);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
